// File: rtl/ex_muldiv.sv
// Iterative RV64M multiply/divide unit: shift-add multiply and restoring divide,
// fixed 64-iteration latency, one operation in flight, one-cycle result strobe.
module ex_muldiv #(
    parameter int unsigned XLEN = 64,
    parameter int unsigned ITER = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [2:0]      funct3_i,
    input  logic            word_i,
    input  logic [XLEN-1:0] op1_i,
    input  logic [XLEN-1:0] op2_i,
    input  logic [4:0]      waddr_i,
    input  logic            flush_i,
    output logic            hold_flag_o,
    output logic            busy_o,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      waddr_o,
    output logic            we_o
);

    localparam int unsigned CW = $clog2(ITER);
    localparam int unsigned AW = 2 * XLEN;
    localparam int unsigned HW = XLEN / 2;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic [2:0]      f3_q;
    logic            word_q;
    logic [4:0]      waddr_q;
    logic [XLEN-1:0] b_q;
    logic [AW-1:0]   acc_q;
    logic            a_neg_q, b_neg_q, div0_q, ovf_q;

    logic            is_div_in, sgn1, sgn2, a_neg, b_neg, div0_in, ovf_in;
    logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, most_neg_in;

    // Operand preparation: W-form extension, sign capture, magnitudes, special cases
    always_comb begin
        is_div_in = funct3_i[2];
        if (is_div_in) begin
            sgn1 = ~funct3_i[0];
            sgn2 = ~funct3_i[0];
        end else begin
            sgn1 = word_i | (funct3_i[1:0] != 2'b11);
            sgn2 = word_i | ~funct3_i[1];
        end
        a_ext = op1_i;
        b_ext = op2_i;
        if (word_i) begin
            a_ext = sgn1 ? {{HW{op1_i[HW-1]}}, op1_i[HW-1:0]} : {{HW{1'b0}}, op1_i[HW-1:0]};
            b_ext = sgn2 ? {{HW{op2_i[HW-1]}}, op2_i[HW-1:0]} : {{HW{1'b0}}, op2_i[HW-1:0]};
        end
        a_neg       = sgn1 & a_ext[XLEN-1];
        b_neg       = sgn2 & b_ext[XLEN-1];
        a_mag       = a_neg ? -a_ext : a_ext;
        b_mag       = b_neg ? -b_ext : b_ext;
        most_neg_in = word_i ? {{(HW+1){1'b1}}, {(HW-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
        div0_in     = is_div_in & (b_ext == '0);
        ovf_in      = is_div_in & sgn1 & (a_ext == most_neg_in) & (b_ext == '1);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_i) state_d = S_CALC;
            S_CALC:  if (cnt_q == CW'(ITER - 1)) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush_i) state_d = S_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // One iteration step for each algorithm; acc holds {high/remainder, low/quotient}
    logic [XLEN:0]   mul_sum, r_sh, diff;
    logic [AW-1:0]   acc_mul, acc_div;
    always_comb begin
        mul_sum = {1'b0, acc_q[AW-1:XLEN]} + {1'b0, (acc_q[0] ? b_q : '0)};
        acc_mul = {mul_sum, acc_q[XLEN-1:1]};
        r_sh    = acc_q[AW-1:XLEN-1];
        diff    = r_sh - {1'b0, b_q};
        acc_div = {(diff[XLEN] ? r_sh[XLEN-1:0] : diff[XLEN-1:0]), acc_q[XLEN-2:0], ~diff[XLEN]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            f3_q    <= '0;
            word_q  <= 1'b0;
            waddr_q <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            a_neg_q <= 1'b0;
            b_neg_q <= 1'b0;
            div0_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (state_q == S_IDLE && start_i && !flush_i) begin
            cnt_q   <= '0;
            f3_q    <= funct3_i;
            word_q  <= word_i;
            waddr_q <= waddr_i;
            b_q     <= b_mag;
            acc_q   <= {XLEN'(0), a_mag};
            a_neg_q <= a_neg;
            b_neg_q <= b_neg;
            div0_q  <= div0_in;
            ovf_q   <= ovf_in;
        end else if (state_q == S_CALC) begin
            cnt_q <= cnt_q + CW'(1);
            acc_q <= f3_q[2] ? acc_div : acc_mul;
        end
    end

    // Output sign fix, result selection and special-case override
    logic [AW-1:0]   prod;
    logic [XLEN-1:0] quo, rem, sel, res;
    always_comb begin
        prod = (a_neg_q ^ b_neg_q) ? -acc_q : acc_q;
        quo  = (a_neg_q ^ b_neg_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem  = a_neg_q ? -acc_q[AW-1:XLEN] : acc_q[AW-1:XLEN];
        if (div0_q) quo = '1;
        if (ovf_q) begin
            quo = word_q ? {{(HW+1){1'b1}}, {(HW-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
            rem = '0;
        end
        if (f3_q[2])                sel = f3_q[1] ? rem : quo;
        else if (word_q)            sel = prod[XLEN-1:0];
        else if (f3_q[1:0] == 2'b00) sel = prod[XLEN-1:0];
        else                        sel = prod[AW-1:XLEN];
        res = word_q ? {{HW{sel[HW-1]}}, sel[HW-1:0]} : sel;
    end

    assign hold_flag_o = ((state_q == S_IDLE) & start_i & ~flush_i) | (state_q == S_CALC);
    assign busy_o      = (state_q != S_IDLE);
    assign valid_o     = (state_q == S_DONE) & ~flush_i;
    assign we_o        = valid_o;
    assign result_o    = valid_o ? res : '0;
    assign waddr_o     = waddr_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed-vector bench for ex_muldiv: table of operations plus flush/reset/ignore sequences.
module tb_ex_muldiv;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic        word;
    logic [63:0] op1, op2;
    logic [4:0]  waddr;
    logic        flush;
    logic        hold_flag_o, busy_o, valid_o, we_o;
    logic [63:0] result_o;
    logic [4:0]  waddr_o;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        string       name;
        logic [2:0]  f3;
        logic        w;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
    } vec_t;

    localparam int unsigned NV = 18;
    vec_t vecs[NV];

    ex_muldiv dut (
        .clk(clk), .rst(rst), .start_i(start), .funct3_i(funct3), .word_i(word),
        .op1_i(op1), .op2_i(op2), .waddr_i(waddr), .flush_i(flush),
        .hold_flag_o(hold_flag_o), .busy_o(busy_o), .valid_o(valid_o),
        .result_o(result_o), .waddr_o(waddr_o), .we_o(we_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Issue one op, wait for the strobe and check latency, stall profile and result
    task automatic run_op(input vec_t v, input logic [4:0] rd, input bit poke);
        int lat;
        int hold_n;
        funct3 = v.f3; word = v.w; op1 = v.a; op2 = v.b; waddr = rd; start = 1'b1;
        #1;
        chk({v.name, " hold@start"}, 64'(hold_flag_o), 64'd1);
        @(posedge clk); #1;
        start = 1'b0; op1 = ~v.a; op2 = 64'd0; waddr = ~rd;
        lat = 0; hold_n = 0;
        while (!valid_o && lat < 200) begin
            if (hold_flag_o) hold_n++;
            if (poke && lat == 5) begin start = 1'b1; funct3 = 3'b101; word = 1'b0; end
            if (poke && lat == 6) start = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        chk({v.name, " latency"}, 64'(lat), 64'd64);
        chk({v.name, " result"}, result_o, v.exp);
        chk({v.name, " waddr"}, 64'(waddr_o), 64'(rd));
        chk({v.name, " we"}, 64'(we_o), 64'd1);
        chk({v.name, " hold@done"}, 64'(hold_flag_o), 64'd0);
        chk({v.name, " hold cycles"}, 64'(hold_n), 64'd64);
        @(posedge clk); #1;
        chk({v.name, " valid after"}, 64'(valid_o), 64'd0);
        chk({v.name, " busy after"}, 64'(busy_o), 64'd0);
    endtask

    initial begin
        vecs[0]  = '{"MUL",       3'b000, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB};
        vecs[1]  = '{"MULHU",     3'b011, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE};
        vecs[2]  = '{"MULH",      3'b001, 1'b0, '1, '1, 64'd0};
        vecs[3]  = '{"MULHSU",    3'b010, 1'b0, '1, 64'd2, '1};
        vecs[4]  = '{"DIV",       3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD};
        vecs[5]  = '{"REM",       3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, '1};
        vecs[6]  = '{"DIVU",      3'b101, 1'b0, 64'd100, 64'd7, 64'd14};
        vecs[7]  = '{"REMU",      3'b111, 1'b0, 64'd100, 64'd7, 64'd2};
        vecs[8]  = '{"DIVU/0",    3'b101, 1'b0, 64'd5, 64'd0, '1};
        vecs[9]  = '{"REM/0",     3'b110, 1'b0, 64'd5, 64'd0, 64'd5};
        vecs[10] = '{"DIV ovf",   3'b100, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000};
        vecs[11] = '{"REM ovf",   3'b110, 1'b0, 64'h8000_0000_0000_0000, '1, 64'd0};
        vecs[12] = '{"DIVW ovf",  3'b100, 1'b1, 64'h1234_5678_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000};
        vecs[13] = '{"MULW",      3'b000, 1'b1, 64'h4000_0000, 64'd2, 64'hFFFF_FFFF_8000_0000};
        vecs[14] = '{"REMUW",     3'b111, 1'b1, 64'h1_0000_0007, 64'd4, 64'd3};
        vecs[15] = '{"DIV -7/0",  3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd0, '1};
        vecs[16] = '{"REM -7/0",  3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd0, 64'hFFFF_FFFF_FFFF_FFF9};
        vecs[17] = '{"MULH W",    3'b001, 1'b1, 64'hABCD_0000_4000_0000, 64'd2, 64'hFFFF_FFFF_8000_0000};

        rst = 1'b1; start = 1'b0; funct3 = '0; word = 1'b0; op1 = '0; op2 = '0; waddr = '0; flush = 1'b0;
        #12;
        chk("reset busy", 64'(busy_o), 64'd0);
        chk("reset valid", 64'(valid_o), 64'd0);
        chk("reset hold", 64'(hold_flag_o), 64'd0);
        chk("reset result", result_o, 64'd0);
        chk("reset waddr", 64'(waddr_o), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < int'(NV); i++) run_op(vecs[i], 5'(i + 3), 1'b0);

        // start pulsed during CALC must not disturb the op in flight
        run_op(vecs[0], 5'd21, 1'b1);

        // flush at edge k+10
        begin
            int seen;
            funct3 = 3'b000; word = 1'b0; op1 = 64'd3; op2 = 64'd4; waddr = 5'd7; start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            repeat (9) begin @(posedge clk); #1; end
            flush = 1'b1;
            @(posedge clk); #1;
            flush = 1'b0;
            chk("flush busy", 64'(busy_o), 64'd0);
            chk("flush hold", 64'(hold_flag_o), 64'd0);
            seen = 0;
            repeat (70) begin @(posedge clk); #1; if (valid_o) seen++; end
            chk("flush no valid", 64'(seen), 64'd0);
        end

        // flush while in DONE suppresses the strobe
        begin
            int lat;
            funct3 = 3'b101; word = 1'b0; op1 = 64'd9; op2 = 64'd3; waddr = 5'd8; start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0; lat = 0;
            while (!busy_o || lat < 64) begin
                if (lat >= 200) break;
                @(posedge clk); #1; lat++;
            end
            chk("done-flush reach done", 64'(valid_o), 64'd1);
            flush = 1'b1;
            #1;
            chk("done-flush valid", 64'(valid_o), 64'd0);
            chk("done-flush we", 64'(we_o), 64'd0);
            @(posedge clk); #1;
            flush = 1'b0;
            chk("done-flush busy", 64'(busy_o), 64'd0);
        end

        // asynchronous reset mid-CALC, then a clean op
        funct3 = 3'b000; word = 1'b0; op1 = 64'd5; op2 = 64'd6; waddr = 5'd30; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        chk("midrst busy", 64'(busy_o), 64'd0);
        chk("midrst hold", 64'(hold_flag_o), 64'd0);
        chk("midrst valid", 64'(valid_o), 64'd0);
        chk("midrst result", result_o, 64'd0);
        chk("midrst waddr", 64'(waddr_o), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        run_op(vecs[6], 5'd17, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Iterative RV64M multiply/divide unit in the EX stage. It consumes the operand pair, destination register and function code that the decode stage issues for OP (funct7=0000001) and OP-32 M-extension instructions. It stalls the pipeline front end while computing, then returns a 64-bit write-back result with a one-cycle valid strobe. One operation is in flight at a time, and every operation has a fixed 64-iteration latency.

## Interface
Parameters:
- XLEN, 64: operand and result width. Only 64 is supported.
- ITER, 64: iteration count per operation. Fixed at XLEN.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start_i  in  1  request. Sampled only in IDLE.
- funct3_i  in  3  M-extension funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- word_i  in  1  1 selects the OP-32 form (MULW/DIVW/DIVUW/REMW/REMUW).
- op1_i  in  64  rs1 value, already forwarded.
- op2_i  in  64  rs2 value, already forwarded.
- waddr_i  in  5  destination register.
- flush_i  in  1  abort the current operation (branch or trap flush).
- hold_flag_o  out  1  pipeline stall request.
- busy_o  out  1  state is not IDLE.
- valid_o  out  1  result strobe, asserted for one cycle.
- result_o  out  64  write-back data. Valid only while valid_o=1; 0 otherwise.
- waddr_o  out  5  destination register latched at start.
- we_o  out  1  equals valid_o.

## Operation
- Clock and reset: one clock. Reset is asynchronous and active-high. Reset forces state to IDLE and clears all registers; every output reads 0.
- States:
  - IDLE: on start_i=1 and flush_i=0, latch funct3, word, waddr and the operand magnitudes/signs, clear the counter, go to CALC.
  - CALC: one iteration per cycle. When counter==63, go to DONE.
  - DONE: drive the result with valid_o=1, then return to IDLE unconditionally.
- Operand preparation:
  - word_i=1: operands are the low 32 bits. Signed ops sign-extend them; unsigned ops zero-extend them.
  - Signed operands are converted to magnitudes; the result sign is recorded.
- Multiply: radix-2 shift-add over a 128-bit accumulator.
  - MUL takes the low 64 bits.
  - MULH, MULHSU and MULHU take the high 64 bits after the sign fix.
  - MULW takes the low 32 bits, sign-extended to 64.
  - word_i=1 with funct3 001–011 executes as MULW.
- Divide: restoring division, unsigned, on magnitudes.
  - Quotient takes the sign of dividend XOR divisor.
  - Remainder takes the sign of the dividend.
  - W forms compute on 32-bit values and sign-extend bit 31 of the result.
- Special cases. These are overridden in DONE; the latency is unchanged.
  - Divisor 0: quotient = all ones (the W forms give 0xFFFF_FFFF_FFFF_FFFF), remainder = dividend (sign-extended from 32 bits for W).
  - Signed overflow (most-negative / -1): quotient = dividend, remainder = 0.
- flush_i: has priority over everything except rst. Next edge goes to IDLE; no valid_o is produced, including when the current state is DONE.
- start_i while busy is ignored; it is the issuer's responsibility to hold the instruction.

## Timing
- Start accepted at edge k: CALC iterations run on edges k+1..k+64, DONE holds in the cycle after edge k+64, and the unit is back in IDLE after edge k+65.
- Latency from accept edge to valid_o is 64 cycles, for all operations including the special cases.
- hold_flag_o = (IDLE & start_i & ~flush_i) | CALC. It is combinational and is low in DONE, so the stalled instruction advances together with the result.
- busy_o is high in CALC and DONE.
- valid_o, we_o, result_o and waddr_o come from DONE-state registers and the output sign fix; there is no combinational path from op1_i or op2_i.
- Back-to-back: a new start_i can be accepted in the IDLE cycle after DONE. Minimum issue interval is 66 cycles.
- An asynchronous rst in any state immediately forces IDLE with all outputs 0.

## Test plan
- MUL 7 × 0xFFFF_FFFF_FFFF_FFFD (-3) → result_o=0xFFFF_FFFF_FFFF_FFEB and waddr_o=latched rd, with valid_o high exactly in the cycle after edge k+64. hold_flag_o is high in the start cycle and in the 64 CALC cycles, and low in DONE.
- MULHU all-ones × all-ones → 0xFFFF_FFFF_FFFF_FFFE. MULH with the same operands → 0x0. MULHSU (-1) × 2 → 0xFFFF_FFFF_FFFF_FFFF.
- DIV -7 / 2 → 0xFFFF_FFFF_FFFF_FFFD. REM -7 / 2 → 0xFFFF_FFFF_FFFF_FFFF. DIVU 100 / 7 → 14. REMU 100 / 7 → 2.
- Special cases:
  - DIVU 5 / 0 → all ones.
  - REM 5 / 0 → 5.
  - DIV 0x8000_0000_0000_0000 / -1 → 0x8000_0000_0000_0000; REM with the same operands → 0.
  - DIVW with low words 0x8000_0000 / 0xFFFF_FFFF → 0xFFFF_FFFF_8000_0000.
- W forms:
  - MULW 0x4000_0000 × 2 → 0xFFFF_FFFF_8000_0000.
  - REMUW 0x1_0000_0007 % 4 → 3 (the upper bits are ignored).
- Abort and ignore:
  - flush_i at edge k+10 → IDLE next cycle, valid_o never asserts, hold_flag_o low.
  - start_i pulsed during CALC → ignored; the first result is unchanged.
  - rst asserted mid-CALC → all outputs 0 immediately; a new operation after reset completes correctly.
